// File: rtl/mode_sequencer.sv
// Operating-mode sequencer: edge-detects debounced buttons, previews a mode and commits it
// to the pipeline over valid/ready, draining the pipeline first when it is running.
// Optional long-press soft clear is built when MODE_SEQ_LONG_PRESS_EN is defined.
module mode_sequencer #(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int NUM_MODES     = 4,
    parameter int DRAIN_CYCLES  = 16,
    parameter int LONG_PRESS_MS = 1000,
    localparam int MW = $clog2(NUM_MODES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_next_db,
    input  logic          btn_prev_db,
    input  logic          btn_apply_db,
    input  logic          run_sw_db,
    input  logic          cfg_ready,
    output logic [MW-1:0] mode_sel,
    output logic [MW-1:0] cfg_mode,
    output logic          cfg_valid,
    output logic          pipeline_en,
    output logic          busy,
    output logic          soft_clear
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam longint HOLD_TICKS = longint'(LONG_PRESS_MS) * longint'(CLK_FREQ_HZ) / 1000;
    localparam logic [MW-1:0] LAST_MODE  = MW'(NUM_MODES - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    if (NUM_MODES < 2 || DRAIN_CYCLES < 1 || HOLD_TICKS < 1) begin : g_param_check
        $error("mode_sequencer: invalid parameter set");
    end

    typedef enum logic [1:0] {
        S_STOP  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          btn_next_p1;
    logic          btn_prev_p1;
    logic          btn_apply_p1;
    logic          next_edge;
    logic          prev_edge;
    logic          apply_edge;
    logic [MW-1:0] mode_sel_r;
    logic [MW-1:0] mode_sel_nxt;
    logic [MW-1:0] cfg_mode_r;
    logic [MW-1:0] cfg_mode_nxt;
    logic          configured;
    logic          configured_nxt;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] drain_cnt_nxt;
    logic          long_hit;

    function automatic logic [MW-1:0] mode_inc(input logic [MW-1:0] m);
        return (m == LAST_MODE) ? '0 : m + 1'b1;
    endfunction

    function automatic logic [MW-1:0] mode_dec(input logic [MW-1:0] m);
        return (m == '0) ? LAST_MODE : m - 1'b1;
    endfunction

    // Previous levels reset high so a button held through reset needs a release first.
    assign next_edge  = btn_next_db  & ~btn_next_p1;
    assign prev_edge  = btn_prev_db  & ~btn_prev_p1;
    assign apply_edge = btn_apply_db & ~btn_apply_p1;

`ifdef MODE_SEQ_LONG_PRESS_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_FULL = HW'(HOLD_TICKS);

    logic [HW-1:0] hold_cnt;
    logic          soft_clear_r;
    logic          hold_active;

    assign hold_active = (state == S_STOP) || (state == S_RUN);
    assign long_hit    = hold_active & btn_apply_db & (hold_cnt == HOLD_LAST);
    assign soft_clear  = soft_clear_r;

    // Saturating hold timer; frozen while a reconfiguration is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt     <= '0;
            soft_clear_r <= 1'b0;
        end else begin
            soft_clear_r <= long_hit;
            if (hold_active) begin
                if (!btn_apply_db) begin
                    hold_cnt <= '0;
                end else if (hold_cnt != HOLD_FULL) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign long_hit   = 1'b0;
    assign soft_clear = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        mode_sel_nxt   = mode_sel_r;
        cfg_mode_nxt   = cfg_mode_r;
        configured_nxt = configured;
        drain_cnt_nxt  = drain_cnt;

        if (next_edge && !prev_edge) begin
            mode_sel_nxt = mode_inc(mode_sel_r);
        end else if (prev_edge && !next_edge) begin
            mode_sel_nxt = mode_dec(mode_sel_r);
        end

        unique case (state)
            S_STOP: begin
                if (apply_edge) begin
                    cfg_mode_nxt = mode_sel_r;
                    state_nxt    = S_ISSUE;
                end else if (run_sw_db && configured) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (apply_edge) begin
                    drain_cnt_nxt = DRAIN_LOAD;
                    state_nxt     = S_DRAIN;
                end else if (!run_sw_db) begin
                    state_nxt = S_STOP;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    cfg_mode_nxt = mode_sel_r;
                    state_nxt    = S_ISSUE;
                end else begin
                    drain_cnt_nxt = drain_cnt - 1'b1;
                end
            end
            S_ISSUE: begin
                // The run switch is only looked at when the offer is accepted.
                if (cfg_ready) begin
                    configured_nxt = 1'b1;
                    state_nxt      = run_sw_db ? S_RUN : S_STOP;
                end
            end
            default: state_nxt = S_STOP;
        endcase

        if (long_hit) begin
            configured_nxt = 1'b0;
            mode_sel_nxt   = '0;
            state_nxt      = S_STOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_next_p1  <= 1'b1;
            btn_prev_p1  <= 1'b1;
            btn_apply_p1 <= 1'b1;
            mode_sel_r   <= '0;
            cfg_mode_r   <= '0;
            configured   <= 1'b0;
            drain_cnt    <= '0;
        end else begin
            btn_next_p1  <= btn_next_db;
            btn_prev_p1  <= btn_prev_db;
            btn_apply_p1 <= btn_apply_db;
            mode_sel_r   <= mode_sel_nxt;
            cfg_mode_r   <= cfg_mode_nxt;
            configured   <= configured_nxt;
            drain_cnt    <= drain_cnt_nxt;
        end
    end

    // Outputs decode registered state only, so cfg_ready never reaches cfg_valid combinationally.
    assign mode_sel    = mode_sel_r;
    assign cfg_mode    = cfg_mode_r;
    assign cfg_valid   = (state == S_ISSUE);
    assign pipeline_en = (state == S_RUN);
    assign busy        = (state == S_DRAIN) || (state == S_ISSUE);

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: selection wrap, stop/run commits, drain timing,
// reset behaviour, and the long-press soft clear (depending on MODE_SEQ_LONG_PRESS_EN).
module tb_mode_sequencer;

    localparam int NUM_MODES     = 4;
    localparam int DRAIN_CYCLES  = 4;
    localparam int CLK_FREQ_HZ   = 1000;
    localparam int LONG_PRESS_MS = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next_db;
    logic       btn_prev_db;
    logic       btn_apply_db;
    logic       run_sw_db;
    logic       cfg_ready;
    logic [1:0] mode_sel;
    logic [1:0] cfg_mode;
    logic       cfg_valid;
    logic       pipeline_en;
    logic       busy;
    logic       soft_clear;

    int n_checks = 0;
    int n_errors = 0;

    mode_sequencer #(
        .CLK_FREQ_HZ  (CLK_FREQ_HZ),
        .NUM_MODES    (NUM_MODES),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .LONG_PRESS_MS(LONG_PRESS_MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_next_db (btn_next_db),
        .btn_prev_db (btn_prev_db),
        .btn_apply_db(btn_apply_db),
        .run_sw_db   (run_sw_db),
        .cfg_ready   (cfg_ready),
        .mode_sel    (mode_sel),
        .cfg_mode    (cfg_mode),
        .cfg_valid   (cfg_valid),
        .pipeline_en (pipeline_en),
        .busy        (busy),
        .soft_clear  (soft_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs set afterwards belong to that cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_next();
        btn_next_db = 1'b1;
        tick();
        btn_next_db = 1'b0;
        tick();
    endtask

    task automatic press_prev();
        btn_prev_db = 1'b1;
        tick();
        btn_prev_db = 1'b0;
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, got 1 expected 0");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_next[5];
        int exp_prev[2];
        int pulses;
        exp_next = '{1, 2, 3, 0, 1};
        exp_prev = '{0, 3};

        rst          = 1'b1;
        btn_next_db  = 1'b1;
        btn_prev_db  = 1'b0;
        btn_apply_db = 1'b0;
        run_sw_db    = 1'b0;
        cfg_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mode_sel",    32'(mode_sel),    0);
        check("rst_cfg_mode",    32'(cfg_mode),    0);
        check("rst_cfg_valid",   32'(cfg_valid),   0);
        check("rst_pipeline_en", 32'(pipeline_en), 0);
        check("rst_busy",        32'(busy),        0);
        check("rst_soft_clear",  32'(soft_clear),  0);
        rst = 1'b0;

        // Next held through reset must not count as an edge
        tick();
        tick();
        check("held_next_no_edge", 32'(mode_sel), 0);
        btn_next_db = 1'b0;
        tick();
        check("held_next_release", 32'(mode_sel), 0);

        for (int i = 0; i < 5; i++) begin
            press_next();
            check($sformatf("next_wrap_%0d", i), 32'(mode_sel), 32'(exp_next[i]));
        end
        for (int i = 0; i < 2; i++) begin
            press_prev();
            check($sformatf("prev_wrap_%0d", i), 32'(mode_sel), 32'(exp_prev[i]));
        end
        btn_next_db = 1'b1;
        btn_prev_db = 1'b1;
        tick();
        btn_next_db = 1'b0;
        btn_prev_db = 1'b0;
        tick();
        check("next_prev_same_cycle", 32'(mode_sel), 3);
        press_prev();
        check("prev_to_2", 32'(mode_sel), 2);

        // Run switch ignored before any handshake
        run_sw_db = 1'b1;
        tick();
        tick();
        check("run_gated_unconfigured", 32'(pipeline_en), 0);
        run_sw_db = 1'b0;
        tick();

        // Apply from stop, then stall the handshake
        btn_apply_db = 1'b1;
        tick();
        check("stop_apply_valid", 32'(cfg_valid),   1);
        check("stop_apply_mode",  32'(cfg_mode),    2);
        check("stop_apply_busy",  32'(busy),        1);
        check("stop_apply_en",    32'(pipeline_en), 0);
        btn_apply_db = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) btn_next_db = 1'b1;
            if (i == 3) btn_next_db = 1'b0;
            tick();
            check($sformatf("stall_valid_%0d", i), 32'(cfg_valid), 1);
            check($sformatf("stall_mode_%0d", i),  32'(cfg_mode),  2);
        end
        check("stall_mode_sel_moves", 32'(mode_sel), 3);
        cfg_ready = 1'b1;
        tick();
        cfg_ready = 1'b0;
        check("hs_valid_drop", 32'(cfg_valid),   0);
        check("hs_busy_drop",  32'(busy),        0);
        check("hs_stop_en",    32'(pipeline_en), 0);

        // Run switch latency once configured
        run_sw_db = 1'b1;
        tick();
        check("run_on",  32'(pipeline_en), 1);
        run_sw_db = 1'b0;
        tick();
        check("run_off", 32'(pipeline_en), 0);
        run_sw_db = 1'b1;
        tick();
        check("run_on_again", 32'(pipeline_en), 1);

        // Reconfigure while running; an apply during the drain is ignored
        btn_apply_db = 1'b1;
        tick();
        check("drain_en_low",   32'(pipeline_en), 0);
        check("drain_busy",     32'(busy),        1);
        check("drain_no_valid", 32'(cfg_valid),   0);
        btn_apply_db = 1'b0;
        tick();
        btn_apply_db = 1'b1;
        tick();
        btn_apply_db = 1'b0;
        tick();
        check("drain_n4_no_valid", 32'(cfg_valid), 0);
        tick();
        check("drain_n5_valid", 32'(cfg_valid), 1);
        check("drain_n5_mode",  32'(cfg_mode),  3);
        cfg_ready = 1'b1;
        tick();
        cfg_ready = 1'b0;
        check("drain_hs_en",    32'(pipeline_en), 1);
        check("drain_hs_valid", 32'(cfg_valid),   0);
        check("drain_hs_busy",  32'(busy),        0);

        // Apply wins over a simultaneous run-switch drop
        btn_apply_db = 1'b1;
        run_sw_db    = 1'b0;
        tick();
        btn_apply_db = 1'b0;
        check("prio_busy", 32'(busy),        1);
        check("prio_en",   32'(pipeline_en), 0);
        repeat (4) tick();
        check("prio_valid", 32'(cfg_valid), 1);
        cfg_ready = 1'b1;
        tick();
        cfg_ready = 1'b0;
        check("prio_hs_stop", 32'(pipeline_en), 0);
        check("prio_hs_valid", 32'(cfg_valid),  0);

        // Asynchronous reset in the middle of an offer
        btn_apply_db = 1'b1;
        tick();
        btn_apply_db = 1'b0;
        check("async_pre_valid", 32'(cfg_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 32'(cfg_valid), 0);
        check("async_busy",  32'(busy),      0);
        check("async_mode",  32'(cfg_mode),  0);
        #2;
        rst = 1'b0;
        tick();
        run_sw_db = 1'b1;
        tick();
        tick();
        check("run_gated_after_reset", 32'(pipeline_en), 0);

        // Configure and run, then hold apply for 12 cycles
        press_next();
        check("lp_mode_sel_pre", 32'(mode_sel), 1);
        cfg_ready    = 1'b1;
        btn_apply_db = 1'b1;
        tick();
        btn_apply_db = 1'b0;
        tick();
        check("lp_running", 32'(pipeline_en), 1);
        tick();
        pulses = 0;
        btn_apply_db = 1'b1;
        repeat (12) begin
            tick();
            if (soft_clear === 1'b1) pulses++;
        end
        btn_apply_db = 1'b0;
        tick();
        if (soft_clear === 1'b1) pulses++;
        cfg_ready = 1'b0;
`ifdef MODE_SEQ_LONG_PRESS_EN
        check("lp_pulses",   32'(pulses),      1);
        check("lp_en_low",   32'(pipeline_en), 0);
        check("lp_mode_sel", 32'(mode_sel),    0);
        tick();
        check("lp_stays_stopped", 32'(pipeline_en), 0);
`else
        check("lp_pulses",   32'(pulses),      0);
        check("lp_en_high",  32'(pipeline_en), 1);
        check("lp_mode_sel", 32'(mode_sel),    1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Operating-mode controller for the vibration DSP pipeline. It takes debounced button and switch levels, maintains a pending mode selection, and commits that mode to the pipeline's configuration port through a valid/ready handshake. When the pipeline is running, it is stopped and drained before any reconfiguration. It sits between the debounced user inputs and the pipeline control/config inputs.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 100_000_000: system clock frequency.
- `NUM_MODES`, 4: number of selectable modes, ≥2. `MW = $clog2(NUM_MODES)`.
- `DRAIN_CYCLES`, 16: cycles `pipeline_en` is held low before a reconfiguration in run, ≥1.
- `LONG_PRESS_MS`, 1000: apply-button hold time that triggers a soft clear. Only used with `LONG_PRESS_EN`.

Ports:
- `clk` input 1: system clock. One clock; all logic is on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `btn_next_db` input 1: debounced level, active-high, synchronous to `clk`.
- `btn_prev_db` input 1: debounced level, same properties.
- `btn_apply_db` input 1: debounced level, same properties.
- `run_sw_db` input 1: debounced run switch level; 1 requests running.
- `cfg_ready` input 1: pipeline accepts the config word.
- `mode_sel` output MW: pending (previewed) mode.
- `cfg_mode` output MW: mode offered or last committed.
- `cfg_valid` output 1: config offer.
- `pipeline_en` output 1: pipeline enable.
- `busy` output 1: high in `S_DRAIN` or `S_ISSUE`.
- `soft_clear` output 1: one-cycle clear pulse.

## Operation
- **Edge detection.**
  - Each button has a registered previous level. A rising edge is `level & ~prev`.
  - The prev registers reset to 1, so a button held through reset must be released before it registers.
- **Selection.**
  - A `next` edge sets `mode_sel` to `(mode_sel+1) mod NUM_MODES`. A `prev` edge sets it to `(mode_sel-1) mod NUM_MODES`. Both wrap: from NUM_MODES-1, next goes to 0; from 0, prev goes to NUM_MODES-1.
  - If next and prev edges occur in the same cycle, both are ignored.
  - Next/prev are honoured in every state. They never alter `cfg_mode` once it has been captured.
- **`configured` flag.** Internal. Set on a completed handshake; cleared by reset and by soft clear.
- **States.**
  - `S_STOP`
    - `pipeline_en`=0.
    - On an apply edge: `cfg_mode` is loaded from `mode_sel`, then go to `S_ISSUE`.
    - Else if `run_sw_db` & `configured`: go to `S_RUN`.
  - `S_RUN`
    - `pipeline_en`=1.
    - On an apply edge: go to `S_DRAIN` and load the drain counter with `DRAIN_CYCLES`-1.
    - Else if `!run_sw_db`: go to `S_STOP`.
  - `S_DRAIN`
    - `pipeline_en`=0. The counter decrements each cycle.
    - At 0: load `cfg_mode` from `mode_sel`, go to `S_ISSUE`.
  - `S_ISSUE`
    - `cfg_valid`=1 and `cfg_mode` is held stable.
    - When `cfg_valid & cfg_ready`: set `configured`, clear `cfg_valid`. Go to `S_RUN` if `run_sw_db`, else `S_STOP`.
- **Apply priority.** Apply edges are ignored in `S_DRAIN` and `S_ISSUE`. An apply edge has priority over a `run_sw_db` change in the same cycle.
- **Drain/issue inputs.** A `run_sw_db` change during `S_DRAIN` or `S_ISSUE` is sampled only at handshake completion. `cfg_valid` is never withdrawn before `cfg_ready`.

## Timing
- **Reset values.**
  - All outputs 0: `mode_sel`, `cfg_mode`, `cfg_valid`, `pipeline_en`, `busy`, `soft_clear`.
  - State `S_STOP`, `configured`=0, counters 0.
- **Apply from stop.** Apply level rises in cycle N → `cfg_valid`=1 in cycle N+1.
- **Apply from run.**
  - `pipeline_en` falls in cycle N+1.
  - `cfg_valid` rises in N+1+`DRAIN_CYCLES`.
- **Handshake.** `cfg_ready` high in cycle M with `cfg_valid`=1 → `cfg_valid`=0 in M+1, and `pipeline_en`=1 in M+1 if running.
- **Run switch.** `run_sw_db` change in cycle N → `pipeline_en` follows in N+1 (stop/run states only).
- **Selection latency.** `mode_sel` updates the cycle after the edge.
- **Combinational path.** `cfg_ready` to `cfg_valid` is registered only; there is no combinational path.

## Configuration
- **Macro:** `MODE_SEQ_LONG_PRESS_EN`.
- **Defined:**
  - A hold counter increments each cycle while `btn_apply_db`=1 in `S_STOP` or `S_RUN`. It resets to 0 when the level is 0. It holds its value in `S_DRAIN`/`S_ISSUE`.
  - Width is `$clog2(LONG_PRESS_MS*CLK_FREQ_HZ/1000+1)`.
  - On reaching `LONG_PRESS_MS*CLK_FREQ_HZ/1000`:
    - `soft_clear` pulses high for one cycle.
    - `configured` is cleared and `mode_sel` set to 0.
    - State is forced to `S_STOP` (`pipeline_en`=0 the next cycle).
    - The counter saturates with no further pulses until release.
  - The initial press still performs a normal apply.
- **Undefined:** no hold counter; `soft_clear` is tied to 0.

## Test plan
- **Reset and wrap.** Reset, then 5 next edges with NUM_MODES=4 → `mode_sel` 1,2,3,0,1. Then 2 prev edges → 0,3. Simultaneous next+prev → unchanged.
- **Stop-state apply.** In stop with `mode_sel`=2, apply edge at N → `cfg_valid`=1 at N+1 with `cfg_mode`=2. Hold `cfg_ready`=0 for 10 cycles → `cfg_valid` stays 1 and `cfg_mode` stays 2. Then `cfg_ready`=1 → `cfg_valid`=0 next cycle.
- **Reconfigure while running.** DRAIN_CYCLES=4, running, apply at N → `pipeline_en`=0 at N+1, `cfg_valid`=1 at N+5. Ready at N+5 → `pipeline_en`=1 at N+6.
- **Run gating.** `run_sw_db`=1 before any handshake → `pipeline_en` stays 0. After a handshake → 1.
- **Held-through-reset and async reset.** Button held through reset release → no edge. Async `rst` pulse mid-`S_ISSUE` → `cfg_valid`=0 immediately, not waiting for a clock edge.
- **Long press** (macro defined, CLK_FREQ_HZ=1000, LONG_PRESS_MS=5).
  - Hold apply 12 cycles in run → exactly one `soft_clear` pulse, `pipeline_en`=0, `mode_sel`=0.
  - Macro undefined → `soft_clear` never asserts.
